// File: rtl/div_pkg.sv
// Shared encodings and constants for the multi-cycle divider.
// Latency: none (declarations only).
// Backpressure: not applicable.
package div_pkg;

    localparam logic        RstEnable         = 1'b1;
    localparam logic [31:0] ZeroWord          = 32'h0000_0000;

    localparam logic        DivStart          = 1'b1;
    localparam logic        DivStop           = 1'b0;
    localparam logic        DivResultReady    = 1'b1;
    localparam logic        DivResultNotReady = 1'b0;
    localparam logic        DivSigned         = 1'b1;
    localparam logic        DivUnsigned       = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider for DIV/DIVU; result_o = {remainder, quotient}.
// Latency: ready_o rises 33 edges after the start edge, 2 edges for a zero divisor.
// Backpressure: result held while start_i stays high; start_i low releases it, annul_i aborts at any time.
module div
    import div_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    div_state_t          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_dvs;       // divisor magnitude
    logic [DATA_W-1:0]   r_quo;       // dividend bits shifting out, quotient bits shifting in
    logic [DATA_W-1:0]   r_rem;       // partial remainder
    logic                r_neg_quo;
    logic                r_neg_rem;
    logic [2*DATA_W-1:0] r_result;
    logic                r_ready;

    logic                w_signed;
    logic                w_op1_neg;
    logic                w_op2_neg;
    logic [DATA_W-1:0]   w_op1_abs;
    logic [DATA_W-1:0]   w_op2_abs;
    logic [DATA_W:0]     w_trial;
    logic [DATA_W-1:0]   w_diff;
    logic                w_ge;
    logic [DATA_W-1:0]   w_rem_step;
    logic [DATA_W-1:0]   w_quo_step;
    logic [DATA_W-1:0]   w_rem_fix;
    logic [DATA_W-1:0]   w_quo_fix;
    logic                w_last;

    // Operand magnitudes, one restoring step, and the sign fix applied on the final step
    always_comb begin
        w_signed   = (signed_div_i != DivUnsigned);
        w_op1_neg  = w_signed && opdata1_i[DATA_W-1];
        w_op2_neg  = w_signed && opdata2_i[DATA_W-1];
        // The most negative value negates to itself, which is its correct unsigned magnitude.
        w_op1_abs  = w_op1_neg ? ('0 - opdata1_i) : opdata1_i;
        w_op2_abs  = w_op2_neg ? ('0 - opdata2_i) : opdata2_i;

        w_trial    = {r_rem, r_quo[DATA_W-1]};
        w_ge       = (w_trial >= {1'b0, r_dvs});
        // When T >= D the difference is below D, so the low DATA_W bits hold it exactly.
        w_diff     = w_trial[DATA_W-1:0] - r_dvs;
        w_rem_step = w_ge ? w_diff : w_trial[DATA_W-1:0];
        w_quo_step = {r_quo[DATA_W-2:0], w_ge};

        w_quo_fix  = r_neg_quo ? ('0 - w_quo_step) : w_quo_step;
        w_rem_fix  = r_neg_rem ? ('0 - w_rem_step) : w_rem_step;
        w_last     = (r_cnt == CNT_W'(DATA_W - 1));
    end

    // Control FSM with working registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_state   <= DivFree;
            r_cnt     <= '0;
            r_dvs     <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_neg_quo <= 1'b0;
            r_neg_rem <= 1'b0;
            r_ready   <= DivResultNotReady;
            r_result  <= {ZeroWord, ZeroWord};
        end else if (annul_i) begin
            r_state  <= DivFree;
            r_cnt    <= '0;
            r_ready  <= DivResultNotReady;
            r_result <= '0;
        end else begin
            case (r_state)
                DivFree: begin
                    r_ready  <= DivResultNotReady;
                    r_result <= '0;
                    if (start_i == DivStart) begin
                        r_neg_quo <= w_op1_neg ^ w_op2_neg;
                        r_neg_rem <= w_op1_neg;
                        if (opdata2_i == '0) begin
                            r_state <= DivByZero;
                        end else begin
                            r_state <= DivOn;
                            r_cnt   <= '0;
                            r_dvs   <= w_op2_abs;
                            r_quo   <= w_op1_abs;
                            r_rem   <= '0;
                        end
                    end
                end
                DivByZero: begin
                    r_state <= DivEnd;
                    r_quo   <= ZeroWord;
                    r_rem   <= ZeroWord;
                end
                DivOn: begin
                    if (w_last) begin
                        r_state <= DivEnd;
                        r_cnt   <= '0;
                        r_quo   <= w_quo_fix;
                        r_rem   <= w_rem_fix;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_quo   <= w_quo_step;
                        r_rem   <= w_rem_step;
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        r_state  <= DivFree;
                        r_ready  <= DivResultNotReady;
                        r_result <= '0;
                    end else begin
                        r_ready  <= DivResultReady;
                        r_result <= {r_rem, r_quo};
                    end
                end
                default: r_state <= DivFree;
            endcase
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule

// File: tb/tb_div.sv
// Bench for the restoring divider: scoreboard of expected {rem, quo} per issued operation.
// Latency: checks exact start-to-ready edge counts.
// Backpressure: exercises result hold, start release, annul and mid-operation reset.
module tb_div;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [63:0] sb_q[$];

    div #(.DATA_W(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    // Reference: native 64-bit division (truncating, remainder takes dividend sign)
    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'h0) return 64'h0;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        sb_q.push_back(model(s, a, b));
    endtask

    // Returns edges from the start edge to the first ready_o, or -1 on timeout
    task automatic wait_ready(output int n);
        n = -1;
        @(posedge clk); #1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (ready_o) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = 32'h0; opdata2_i = 32'h0;
        repeat (3) tick();
        vectors++;
        if (ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready: got %b, want 0", ready_o);
        end
        vectors++;
        if (result_o !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_result: got %h, want 0", result_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_divu_basic;
        int n;
        logic [63:0] exp;
        issue(DivUnsigned, 32'd100, 32'd7);
        wait_ready(n);
        exp = sb_q.pop_front();
        vectors++;
        if (n !== 33) begin
            miscompares++;
            $display("FAIL divu_latency: got %0d edges, want 33", n);
        end
        vectors++;
        if (result_o !== 64'h00000002_0000000E) begin
            miscompares++;
            $display("FAIL divu_result: got %h, want 000000020000000e", result_o);
        end
        tick();
        vectors++;
        if (ready_o !== 1'b1 || result_o !== exp) begin
            miscompares++;
            $display("FAIL divu_hold: got ready=%b result=%h, want ready=1 result=%h", ready_o, result_o, exp);
        end
        start_i = 1'b0;
        tick();
        vectors++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            miscompares++;
            $display("FAIL divu_release: got ready=%b result=%h, want 0/0", ready_o, result_o);
        end
    endtask

    task automatic test_signed;
        logic [31:0] a_tab [4];
        logic [31:0] b_tab [4];
        logic        s_tab [4];
        int n;
        logic [63:0] exp;
        a_tab = '{32'hFFFFFFF9, 32'h00000007, 32'h80000000, 32'hFFFFFFFF};
        b_tab = '{32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001};
        s_tab = '{DivSigned, DivSigned, DivSigned, DivUnsigned};
        for (int i = 0; i < 4; i++) begin
            issue(s_tab[i], a_tab[i], b_tab[i]);
            wait_ready(n);
            exp = sb_q.pop_front();
            vectors++;
            if (n !== 33) begin
                miscompares++;
                $display("FAIL signed_latency[%0d]: got %0d edges, want 33", i, n);
            end
            vectors++;
            if (result_o !== exp) begin
                miscompares++;
                $display("FAIL signed_result[%0d]: got %h, want %h", i, result_o, exp);
            end
            start_i = 1'b0;
            tick();
            vectors++;
            if (ready_o !== 1'b0) begin
                miscompares++;
                $display("FAIL signed_release[%0d]: got ready=%b, want 0", i, ready_o);
            end
        end
    endtask

    task automatic test_div_by_zero;
        int n;
        logic [63:0] exp;
        issue(DivUnsigned, 32'd5, 32'd0);
        wait_ready(n);
        exp = sb_q.pop_front();
        vectors++;
        if (n !== 2) begin
            miscompares++;
            $display("FAIL byzero_latency: got %0d edges, want 2", n);
        end
        vectors++;
        if (result_o !== exp) begin
            miscompares++;
            $display("FAIL byzero_result: got %h, want %h", result_o, exp);
        end
        start_i = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        int n;
        int lat;
        logic [63:0] exp;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 8; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            if (i == 0) b = 32'hFFFFFFF3;
            lat = (b == 32'h0) ? 2 : 33;
            issue(s, a, b);
            wait_ready(n);
            exp = sb_q.pop_front();
            vectors++;
            if (n !== lat || result_o !== exp) begin
                miscompares++;
                $display("FAIL b2b[%0d] s=%b %h/%h: got %0d edges result=%h, want %0d edges result=%h",
                         i, s, a, b, n, result_o, lat, exp);
            end
            start_i = 1'b0;
            tick();
        end
    endtask

    task automatic test_annul;
        int n;
        logic [63:0] exp;
        logic [63:0] dropped;
        logic        seen;
        issue(DivUnsigned, 32'd1000, 32'd3);
        dropped = sb_q.pop_front();
        tick();
        repeat (9) tick();
        annul_i = 1'b1;
        start_i = 1'b0;
        tick();
        annul_i = 1'b0;
        vectors++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            miscompares++;
            $display("FAIL annul_outputs: got ready=%b result=%h (dropped %h), want 0/0", ready_o, result_o, dropped);
        end
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (ready_o) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL annul_no_ready: got ready seen=%b, want 0", seen);
        end
        issue(DivUnsigned, 32'd9, 32'd4);
        wait_ready(n);
        exp = sb_q.pop_front();
        vectors++;
        if (n !== 33 || result_o !== exp) begin
            miscompares++;
            $display("FAIL annul_restart: got %0d edges result=%h, want 33 edges result=%h", n, result_o, exp);
        end
        start_i = 1'b0;
        tick();
    endtask

    task automatic test_rst_midop;
        int n;
        logic [63:0] exp;
        issue(DivUnsigned, 32'd123456, 32'd789);
        tick();
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            miscompares++;
            $display("FAIL rst_midop_outputs: got ready=%b result=%h, want 0/0", ready_o, result_o);
        end
        wait_ready(n);
        exp = sb_q.pop_front();
        vectors++;
        if (n !== 33 || result_o !== exp) begin
            miscompares++;
            $display("FAIL rst_midop_restart: got %0d edges result=%h, want 33 edges result=%h", n, result_o, exp);
        end
        start_i = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_div_by_zero();
        test_back_to_back();
        test_annul();
        test_rst_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
